// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one bit-serial logical shift engine between two requesters.
// Optional build macro SHIFT_ARB_FAST_EN: step 4 positions per cycle while the remaining count is >= 4.
module shift_arbiter #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 6
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_data,
  input  logic [AMT_W-1:0] req0_amount,
  input  logic             req0_dir,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_data,
  input  logic [AMT_W-1:0] req1_amount,
  input  logic             req1_dir,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_id
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] data_next;
  logic [AMT_W-1:0] count;
  logic [AMT_W-1:0] count_next;
  logic             dir;
  logic             dir_next;
  logic             id;
  logic             id_next;
  logic             last;
  logic             last_next;
  logic             grant0;
  logic             grant1;

  // Round-robin grant; last == 1 means requester 1 was served most recently.
  always_comb begin
    grant0     = req0_valid && (!req1_valid || last);
    grant1     = req1_valid && (!req0_valid || !last);
    req0_ready = reset_n && (state == IDLE) && grant0;
    req1_ready = reset_n && (state == IDLE) && grant1;
  end

  // Next-state and datapath; an amount of zero still spends one cycle in SHIFT.
  always_comb begin
    state_next = state;
    data_next  = data;
    count_next = count;
    dir_next   = dir;
    id_next    = id;
    last_next  = last;
    case (state)
      IDLE: begin
        if (grant0) begin
          data_next  = req0_data;
          count_next = req0_amount;
          dir_next   = req0_dir;
          id_next    = 1'b0;
          last_next  = 1'b0;
          state_next = SHIFT;
        end else if (grant1) begin
          data_next  = req1_data;
          count_next = req1_amount;
          dir_next   = req1_dir;
          id_next    = 1'b1;
          last_next  = 1'b1;
          state_next = SHIFT;
        end else begin
          state_next = IDLE;
        end
      end
      SHIFT: begin
`ifdef SHIFT_ARB_FAST_EN
        if (count >= AMT_W'(4)) begin
          data_next  = dir ? (data >> 3'd4) : (data << 3'd4);
          count_next = count - AMT_W'(4);
        end else if (count != '0) begin
          data_next  = dir ? (data >> 1'b1) : (data << 1'b1);
          count_next = count - AMT_W'(1);
        end else begin
          data_next  = data;
          count_next = count;
        end
`else
        if (count != '0) begin
          data_next  = dir ? (data >> 1'b1) : (data << 1'b1);
          count_next = count - AMT_W'(1);
        end else begin
          data_next  = data;
          count_next = count;
        end
`endif
        if (count_next == '0) begin
          state_next = DONE;
        end else begin
          state_next = SHIFT;
        end
      end
      DONE: begin
        if (resp_ready) begin
          state_next = IDLE;
        end else begin
          state_next = DONE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and datapath registers; resp_valid is registered from the next state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      data       <= '0;
      count      <= '0;
      dir        <= 1'b0;
      id         <= 1'b0;
      last       <= 1'b1;
      resp_valid <= 1'b0;
    end else begin
      state      <= state_next;
      data       <= data_next;
      count      <= count_next;
      dir        <= dir_next;
      id         <= id_next;
      last       <= last_next;
      resp_valid <= (state_next == DONE);
    end
  end

  assign resp_data = data;
  assign resp_id   = id;

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed self-checking bench for shift_arbiter; expected latencies follow SHIFT_ARB_FAST_EN if defined.
module tb_shift_arbiter;

  logic        clock;
  logic        reset_n;
  logic        req0_valid, req0_ready, req0_dir;
  logic [31:0] req0_data;
  logic [5:0]  req0_amount;
  logic        req1_valid, req1_ready, req1_dir;
  logic [31:0] req1_data;
  logic [5:0]  req1_amount;
  logic        resp_valid, resp_ready, resp_id;
  logic [31:0] resp_data;

  int total = 0;
  int bad   = 0;

  shift_arbiter #(.WIDTH(32), .AMT_W(6)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_data   (req0_data),
    .req0_amount (req0_amount),
    .req0_dir    (req0_dir),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_data   (req1_data),
    .req1_amount (req1_amount),
    .req1_dir    (req1_dir),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_data   (resp_data),
    .resp_id     (resp_id)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic int exp_lat(input int a);
    int l;
`ifdef SHIFT_ARB_FAST_EN
    l = a / 4 + a % 4;
`else
    l = a;
`endif
    return (l < 1) ? 1 : l;
  endfunction

  // Drive one requester until it is accepted; returns just after the accepting edge.
  task automatic accept_op(input int which, input logic [31:0] d, input logic [5:0] a, input logic dr);
    int w;
    if (which == 0) begin
      req0_valid = 1'b1; req0_data = d; req0_amount = a; req0_dir = dr;
    end else begin
      req1_valid = 1'b1; req1_data = d; req1_amount = a; req1_dir = dr;
    end
    #1;
    w = 0;
    while (!((which == 0) ? req0_ready : req1_ready) && w < 50) begin
      @(posedge clock); #1; #1;
      w++;
    end
    total++;
    if (w >= 50) begin
      bad++;
      $display("FAIL accept_timeout: requester %0d never saw ready", which);
    end
    @(posedge clock); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  // Count edges from the accepting edge until resp_valid is seen.
  task automatic wait_resp(output int lat, output logic [31:0] rd, output logic rid);
    lat = 0;
    while (!resp_valid && lat < 200) begin
      @(posedge clock); #1;
      lat++;
    end
    rd  = resp_data;
    rid = resp_id;
  endtask

  task automatic take_resp();
    resp_ready = 1'b1;
    @(posedge clock); #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_data = 32'h0; req0_amount = 6'd0; req0_dir = 1'b0;
    req1_data = 32'h0; req1_amount = 6'd0; req1_dir = 1'b0;
    resp_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    total++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      bad++; $display("FAIL reset_ready: got %b%b want 00", req0_ready, req1_ready);
    end
    total++;
    if (resp_valid !== 1'b0 || resp_data !== 32'h0 || resp_id !== 1'b0) begin
      bad++; $display("FAIL reset_resp: got v=%b d=%h id=%b want 0/0/0", resp_valid, resp_data, resp_id);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_contention();
    int grants[$];
    int ids[$];
    logic [31:0] datas[$];
    int both = 0;
    int cyc = 0;
    logic [31:0] exp_d;
    req0_data = 32'h0000_0001; req0_amount = 6'd1; req0_dir = 1'b0;
    req1_data = 32'h0000_0080; req1_amount = 6'd1; req1_dir = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    resp_ready = 1'b1;
    #1;
    while (ids.size() < 4 && cyc < 100) begin
      if (req0_ready && req1_ready) both++;
      if (req0_ready) grants.push_back(0);
      if (req1_ready) grants.push_back(1);
      if (resp_valid) begin
        ids.push_back(int'(resp_id));
        datas.push_back(resp_data);
      end
      @(posedge clock); #1; #1;
      cyc++;
    end
    req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b0;
    total++;
    if (both != 0) begin
      bad++; $display("FAIL contention_both_ready: got %0d cycles want 0", both);
    end
    total++;
    if (ids.size() != 4 || grants.size() < 4) begin
      bad++; $display("FAIL contention_count: got %0d resps %0d grants want 4", ids.size(), grants.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        exp_d = (i % 2 == 0) ? 32'h0000_0002 : 32'h0000_0040;
        total++;
        if (grants[i] != i % 2 || ids[i] != i % 2 || datas[i] !== exp_d) begin
          bad++;
          $display("FAIL contention_op%0d: got grant=%0d id=%0d data=%h want %0d/%0d/%h",
                   i, grants[i], ids[i], datas[i], i % 2, i % 2, exp_d);
        end
      end
    end
    @(posedge clock); #1;
  endtask

  task automatic test_single();
    int lat; logic [31:0] rd; logic rid;
    accept_op(0, 32'h0000_0C00, 6'd3, 1'b1);
    wait_resp(lat, rd, rid);
    total++;
    if (rd !== 32'h0000_0180 || rid !== 1'b0 || lat != exp_lat(3)) begin
      bad++; $display("FAIL single_right: got d=%h id=%b lat=%0d want 00000180/0/%0d", rd, rid, lat, exp_lat(3));
    end
    take_resp();
    accept_op(0, 32'h0000_0C00, 6'd3, 1'b0);
    wait_resp(lat, rd, rid);
    total++;
    if (rd !== 32'h0000_6000 || rid !== 1'b0 || lat != exp_lat(3)) begin
      bad++; $display("FAIL single_left: got d=%h id=%b lat=%0d want 00006000/0/%0d", rd, rid, lat, exp_lat(3));
    end
    take_resp();
  endtask

  task automatic test_boundary();
    int lat; logic [31:0] rd; logic rid;
    accept_op(1, 32'hDEAD_BEEF, 6'd0, 1'b0);
    wait_resp(lat, rd, rid);
    total++;
    if (rd !== 32'hDEAD_BEEF || rid !== 1'b1 || lat != 1) begin
      bad++; $display("FAIL amount0: got d=%h id=%b lat=%0d want deadbeef/1/1", rd, rid, lat);
    end
    take_resp();
    accept_op(0, 32'hFFFF_FFFF, 6'd32, 1'b0);
    wait_resp(lat, rd, rid);
    total++;
    if (rd !== 32'h0 || lat != exp_lat(32)) begin
      bad++; $display("FAIL amount32_left: got d=%h lat=%0d want 00000000/%0d", rd, lat, exp_lat(32));
    end
    take_resp();
    accept_op(1, 32'hFFFF_FFFF, 6'd40, 1'b1);
    wait_resp(lat, rd, rid);
    total++;
    if (rd !== 32'h0 || lat != exp_lat(40)) begin
      bad++; $display("FAIL amount40_right: got d=%h lat=%0d want 00000000/%0d", rd, lat, exp_lat(40));
    end
    take_resp();
    accept_op(0, 32'h8000_0000, 6'd9, 1'b1);
    wait_resp(lat, rd, rid);
    total++;
    if (rd !== 32'h0040_0000 || lat != exp_lat(9)) begin
      bad++; $display("FAIL amount9_right: got d=%h lat=%0d want 00400000/%0d", rd, lat, exp_lat(9));
    end
    take_resp();
  endtask

  task automatic test_backpressure();
    int lat; logic [31:0] rd; logic rid;
    accept_op(1, 32'h0000_00F0, 6'd4, 1'b0);
    wait_resp(lat, rd, rid);
    total++;
    if (rd !== 32'h0000_0F00 || rid !== 1'b1 || lat != exp_lat(4)) begin
      bad++; $display("FAIL bp_first: got d=%h id=%b lat=%0d want 00000f00/1/%0d", rd, rid, lat, exp_lat(4));
    end
    req0_valid = 1'b1; req0_data = 32'h0000_0005; req0_amount = 6'd2; req0_dir = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      total++;
      if (resp_valid !== 1'b1 || resp_data !== 32'h0000_0F00 || resp_id !== 1'b1 || req0_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold%0d: got v=%b d=%h id=%b r0=%b want 1/00000f00/1/0",
                 i, resp_valid, resp_data, resp_id, req0_ready);
      end
    end
    take_resp();
    #1;
    total++;
    if (resp_valid !== 1'b0 || req0_ready !== 1'b1) begin
      bad++; $display("FAIL bp_next_accept: got v=%b r0=%b want 0/1", resp_valid, req0_ready);
    end
    @(posedge clock); #1;
    req0_valid = 1'b0;
    wait_resp(lat, rd, rid);
    total++;
    if (rd !== 32'h0000_0014 || rid !== 1'b0 || lat != exp_lat(2)) begin
      bad++; $display("FAIL bp_second: got d=%h id=%b lat=%0d want 00000014/0/%0d", rd, rid, lat, exp_lat(2));
    end
    take_resp();
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    int lat; logic [31:0] rd; logic rid;
    accept_op(0, 32'hFFFF_0000, 6'd20, 1'b1);
    @(posedge clock); #1;
    @(posedge clock); #2;
    reset_n = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    total++;
    if (resp_valid !== 1'b0 || resp_data !== 32'h0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      bad++;
      $display("FAIL midreset_regs: got v=%b d=%h r=%b%b want 0/00000000/00",
               resp_valid, resp_data, req0_ready, req1_ready);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clock); #1;
      if (resp_valid) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++; $display("FAIL midreset_no_resp: got %0d valid cycles want 0", seen);
    end
    req0_valid = 1'b1; req0_data = 32'h0000_1234; req0_amount = 6'd4; req0_dir = 1'b0;
    req1_valid = 1'b1; req1_data = 32'h0000_00FF; req1_amount = 6'd1; req1_dir = 1'b1;
    #1;
    total++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      bad++; $display("FAIL midreset_tie: got r0=%b r1=%b want 1/0", req0_ready, req1_ready);
    end
    @(posedge clock); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_resp(lat, rd, rid);
    total++;
    if (rd !== 32'h0001_2340 || rid !== 1'b0 || lat != exp_lat(4)) begin
      bad++; $display("FAIL midreset_op: got d=%h id=%b lat=%0d want 00012340/0/%0d", rd, rid, lat, exp_lat(4));
    end
    take_resp();
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single();
    test_boundary();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
